// File: rtl/wb_drain_if.sv
// rtl/wb_drain_if.sv - write-buffer read side and downstream beat stream of the drain engine
interface wb_drain_if #(
   parameter int LINE_W = 512,
   parameter int BEAT_W = 128
);
   logic              enable_i;
   logic              aempty_i;
   logic              rden_o;
   logic [LINE_W-1:0] rdata_i;
   logic              wvalid_o;
   logic              wready_i;
   logic [BEAT_W-1:0] wdata_o;
   logic              wlast_o;
   logic              busy_o;
   logic [15:0]       lines_o;

   modport slave (
      input  enable_i, aempty_i, rdata_i, wready_i,
      output rden_o, wvalid_o, wdata_o, wlast_o, busy_o, lines_o
   );

   modport master (
      output enable_i, aempty_i, rdata_i, wready_i,
      input  rden_o, wvalid_o, wdata_o, wlast_o, busy_o, lines_o
   );
endinterface

// File: rtl/wb_drain.sv
// rtl/wb_drain.sv - pops one line from the write buffer and streams it downstream as NBEATS beats
module wb_drain #(
   parameter int LINE_W = 512,
   parameter int BEAT_W = 128
) (
   input  logic      clk,
   input  logic      rst,
   wb_drain_if.slave bus
);
   localparam int NBEATS = LINE_W / BEAT_W;
   localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
   localparam logic [1:0] SEND  = 2'd3;

   logic [1:0]        state_q;
   logic [BCW-1:0]    beat_q;
   logic [LINE_W-1:0] line_q;
   logic [15:0]       lines_q;

   logic start_ok;
   logic in_send;
   logic at_last;
   logic xfer;

   assign start_ok = bus.enable_i && !bus.aempty_i;
   assign in_send  = (state_q == SEND);
   assign at_last  = (beat_q == LAST_BEAT);
   assign xfer     = in_send && bus.wready_i;

   // aempty_i/enable_i only matter in IDLE and on the last-beat transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         line_q  <= '0;
         lines_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_ok)
                  state_q <= FETCH;
            end
            FETCH: begin
               state_q <= LOAD;
            end
            LOAD: begin
               line_q  <= bus.rdata_i;
               beat_q  <= '0;
               state_q <= SEND;
            end
            SEND: begin
               if (xfer) begin
                  if (at_last) begin
                     lines_q <= lines_q + 16'd1;
                     state_q <= start_ok ? FETCH : IDLE;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rden_o   = (state_q == FETCH);
   assign bus.wvalid_o = in_send;
   assign bus.wlast_o  = in_send && at_last;
   assign bus.wdata_o  = line_q[int'(beat_q)*BEAT_W +: BEAT_W];
   assign bus.busy_o   = (state_q != IDLE);
   assign bus.lines_o  = lines_q;
endmodule

// File: tb/tb_wb_drain.sv
// tb/tb_wb_drain.sv - directed table-driven bench for wb_drain
module tb_wb_drain;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_drain_if #(.LINE_W(512), .BEAT_W(128)) bus ();
   wb_drain #(.LINE_W(512), .BEAT_W(128)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [511:0]      line;
      logic [3:0][127:0] beats;
   } vec_t;

   logic [511:0] mem [16];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int cyc = 0;
   logic [127:0] cap_data [$];
   logic         cap_last [$];
   int           rden_cyc [$];
   int n_cmp = 0;
   int n_fail = 0;

   assign bus.aempty_i = (wr_ptr == rd_ptr);

   always @(posedge clk) cyc <= cyc + 1;

   // write-buffer model and downstream monitor, both sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wvalid_o && bus.wready_i) begin
            cap_data.push_back(bus.wdata_o);
            cap_last.push_back(bus.wlast_o);
         end
         if (bus.rden_o) begin
            rden_cyc.push_back(cyc);
            bus.rdata_i <= mem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
         end
      end
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [511:0] d);
      mem[wr_ptr % 16] = d;
      wr_ptr++;
   endtask

   task automatic clear_caps();
      cap_data.delete();
      cap_last.delete();
      rden_cyc.delete();
   endtask

   task automatic wait_lines(input logic [15:0] target, input int budget, input string name);
      int n = 0;
      while (bus.lines_o !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, bus.lines_o, target);
   endtask

   task automatic wait_beat(input logic [127:0] d, input int budget, input string name);
      int n = 0;
      while (!(bus.wvalid_o === 1'b1 && bus.wdata_o === d) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, bus.wdata_o, d);
   endtask

   function automatic logic [127:0] cap_at(input int i);
      return (i < cap_data.size()) ? cap_data[i] : 128'hx;
   endfunction

   function automatic logic last_at(input int i);
      return (i < cap_last.size()) ? cap_last[i] : 1'bx;
   endfunction

   vec_t vecs [5];

   initial begin
      vecs[0] = '{512'hAA, {128'h0, 128'h0, 128'h0, 128'hAA}};
      vecs[1] = '{{128'h4, 128'h3, 128'h2, 128'h1}, {128'h4, 128'h3, 128'h2, 128'h1}};
      vecs[2] = '{{128'h0, {128{1'b1}}, 128'h0, 128'h1234},
                  {128'h0, {128{1'b1}}, 128'h0, 128'h1234}};
      vecs[3] = '{512'h7 | (512'h1 << 384), {128'h1, 128'h0, 128'h0, 128'h7}};
      vecs[4] = '{{512{1'b1}}, {{128{1'b1}}, {128{1'b1}}, {128{1'b1}}, {128{1'b1}}}};

      bus.enable_i = 1'b0;
      bus.wready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rden", bus.rden_o, 1'b0);
      check("rst_wvalid", bus.wvalid_o, 1'b0);
      check("rst_wlast", bus.wlast_o, 1'b0);
      check("rst_wdata", bus.wdata_o, 128'h0);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_lines", bus.lines_o, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", bus.busy_o, 1'b0);

      for (int i = 0; i < 5; i++) begin
         clear_caps();
         push(vecs[i].line);
         bus.enable_i = 1'b1;
         bus.wready_i = 1'b1;
         wait_lines(16'(i + 1), 40, "tbl_lines");
         check("tbl_busy_after", bus.busy_o, 1'b0);
         check("tbl_nbeats", cap_data.size(), 4);
         check("tbl_nrden", rden_cyc.size(), 1);
         for (int b = 0; b < 4; b++) begin
            check("tbl_wdata", cap_at(b), vecs[i].beats[b]);
            check("tbl_wlast", last_at(b), (b == 3));
         end
         bus.enable_i = 1'b0;
      end

      // back-to-back: second fetch exactly NBEATS+2 cycles after the first
      clear_caps();
      push(512'hAA);
      push(512'hBB);
      bus.enable_i = 1'b1;
      wait_lines(16'd7, 60, "b2b_lines");
      check("b2b_nrden", rden_cyc.size(), 2);
      if (rden_cyc.size() == 2)
         check("b2b_spacing", rden_cyc[1] - rden_cyc[0], 6);
      check("b2b_nbeats", cap_data.size(), 8);
      check("b2b_beat0", cap_at(0), 128'hAA);
      check("b2b_beat3", cap_at(3), 128'h0);
      check("b2b_beat4", cap_at(4), 128'hBB);
      check("b2b_last3", last_at(3), 1'b1);
      check("b2b_last4", last_at(4), 1'b0);
      check("b2b_last7", last_at(7), 1'b1);
      bus.enable_i = 1'b0;

      // backpressure: stall three cycles on beat 2
      clear_caps();
      bus.wready_i = 1'b0;
      push({128'h4, 128'h3, 128'h2, 128'h1});
      bus.enable_i = 1'b1;
      wait_beat(128'h1, 20, "bp_first_beat");
      bus.enable_i = 1'b0;
      @(posedge clk);
      #1 bus.wready_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 bus.wready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_hold_wdata", bus.wdata_o, 128'h3);
         check("bp_hold_wvalid", bus.wvalid_o, 1'b1);
         check("bp_hold_wlast", bus.wlast_o, 1'b0);
      end
      check("bp_count_stalled", cap_data.size(), 2);
      @(posedge clk);
      #1 bus.wready_i = 1'b1;
      wait_lines(16'd8, 20, "bp_lines");
      check("bp_nbeats", cap_data.size(), 4);
      for (int b = 0; b < 4; b++)
         check("bp_wdata", cap_at(b), 128'(b + 1));

      // gating: no fetch while disabled; dropping enable mid-line finishes the line only
      clear_caps();
      push({128'hA3, 128'hA2, 128'hA1, 128'hA0});
      push({128'hC3, 128'hC2, 128'hC1, 128'hC0});
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("gate_rden", bus.rden_o, 1'b0);
         check("gate_busy", bus.busy_o, 1'b0);
      end
      bus.enable_i = 1'b1;
      wait_beat(128'hA0, 20, "gate_first_beat");
      bus.enable_i = 1'b0;
      wait_lines(16'd9, 20, "gate_lines");
      repeat (4) @(negedge clk);
      check("gate_busy_after", bus.busy_o, 1'b0);
      check("gate_nrden", rden_cyc.size(), 1);
      check("gate_nbeats", cap_data.size(), 4);
      check("gate_beat3", cap_at(3), 128'hA3);

      // asynchronous reset in the middle of a line
      bus.enable_i = 1'b1;
      wait_beat(128'hC1, 20, "rst_mid_beat1");
      #1 rst = 1'b1;
      #1;
      check("rstm_wvalid", bus.wvalid_o, 1'b0);
      check("rstm_lines", bus.lines_o, 16'h0);
      check("rstm_busy", bus.busy_o, 1'b0);
      check("rstm_wdata", bus.wdata_o, 128'h0);
      check("rstm_wlast", bus.wlast_o, 1'b0);
      clear_caps();
      push({128'hD3, 128'hD2, 128'hD1, 128'hD0});
      @(posedge clk);
      @(negedge clk);
      check("rstm_held_busy", bus.busy_o, 1'b0);
      rst = 1'b0;
      wait_lines(16'd1, 40, "rstm_restart_lines");
      check("rstm_nbeats", cap_data.size(), 4);
      check("rstm_beat0", cap_at(0), 128'hD0);
      check("rstm_beat3", cap_at(3), 128'hD3);
      bus.enable_i = 1'b0;

      // counter wrap, preloaded just below the top
      @(negedge clk);
      force dut.lines_q = 16'hFFFE;
      #1 release dut.lines_q;
      @(negedge clk);
      check("wrap_preload", bus.lines_o, 16'hFFFE);
      push(512'h11);
      push(512'h22);
      bus.enable_i = 1'b1;
      wait_lines(16'hFFFF, 20, "wrap_ffff");
      wait_lines(16'h0000, 20, "wrap_zero");
      bus.enable_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
